// File: rtl/io_pattern_sequencer_pkg.sv
// Shared types for the IO pattern sequencer.
//   state_e     : sequencer FSM state
//   DEF_*       : default geometry used by the sequencer, its interface and its table
package io_sequencer_pkg;

   localparam int unsigned DEF_WIDTH      = 1;
   localparam int unsigned DEF_DEPTH      = 16;
   localparam int unsigned DEF_HOLD_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/io_pattern_sequencer_if.sv
// Bundle of the sequencer's table-load port, playback controls, status and pattern output.
//   slave  : sequencer side (accepts entries and controls, drives status and io_out)
//   master : stimulus side
interface io_pattern_sequencer_if
   import io_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned HOLD_WIDTH = DEF_HOLD_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic                  s_valid;
   logic                  s_ready;
   logic [WIDTH-1:0]      s_data;
   logic [HOLD_WIDTH-1:0] s_hold;
   logic                  clear;
   logic                  start;
   logic                  abort;
   logic                  loop_en;
   logic [CW-1:0]         count;
   logic                  busy;
   logic                  done;
   logic                  aborted;
   logic [WIDTH-1:0]      io_out;

   modport slave (
      input  s_valid, s_data, s_hold, clear, start, abort, loop_en,
      output s_ready, count, busy, done, aborted, io_out
   );

   modport master (
      output s_valid, s_data, s_hold, clear, start, abort, loop_en,
      input  s_ready, count, busy, done, aborted, io_out
   );
endinterface

// File: rtl/io_pattern_sequencer_mem.sv
// Pattern table: DEPTH entries of {value, hold}, one write port, one combinational read port.
//   clk                        : write clock
//   wr_en/wr_addr/wr_value/wr_hold : entry write
//   rd_addr/rd_value/rd_hold   : asynchronous entry read
// Contents are deliberately not reset; only the entry count in the sequencer qualifies them.
module io_pattern_mem #(
   parameter int unsigned WIDTH      = 1,
   parameter int unsigned HOLD_WIDTH = 16,
   parameter int unsigned DEPTH      = 16,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [WIDTH-1:0]      wr_value,
   input  logic [HOLD_WIDTH-1:0] wr_hold,
   input  logic [AW-1:0]         rd_addr,
   output logic [WIDTH-1:0]      rd_value,
   output logic [HOLD_WIDTH-1:0] rd_hold
);
   typedef struct packed {
      logic [WIDTH-1:0]      value;
      logic [HOLD_WIDTH-1:0] hold;
   } entry_t;

   entry_t mem_q [DEPTH];

   // Table write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr].value <= wr_value;
         mem_q[wr_addr].hold  <= wr_hold;
      end
   end

   assign rd_value = mem_q[rd_addr].value;
   assign rd_hold  = mem_q[rd_addr].hold;
endmodule

// File: rtl/io_pattern_sequencer.sv
// Plays a loaded table of (value, hold) entries onto io_out, each value for hold+1 cycles,
// optionally looping over the table until loop_en is low at a pass end.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : table-load port, start/clear/abort/loop_en controls, count/busy/done/aborted
//                 status and io_out pattern output
// s_ready, done and aborted also depend on the current clear/abort inputs so that a
// clear blocks a same-cycle write and an abort suppresses done in the cycle it occurs.
module io_pattern_sequencer
   import io_sequencer_pkg::*;
#(
   parameter int unsigned     WIDTH      = DEF_WIDTH,
   parameter int unsigned     DEPTH      = DEF_DEPTH,
   parameter int unsigned     HOLD_WIDTH = DEF_HOLD_WIDTH,
   parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
   input  logic                   clk,
   input  logic                   resetn,
   io_pattern_sequencer_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   state_e                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [AW-1:0]         idx_q, idx_d, rd_addr;
   logic [HOLD_WIDTH-1:0] hold_q, hold_d, rd_hold;
   logic [WIDTH-1:0]      io_q, io_d, rd_value;
   logic                  s_ready_c, wr_en, last_entry;

   assign s_ready_c  = (state_q == ST_IDLE) && (count_q < CW'(DEPTH)) && !bus.clear;
   assign wr_en      = bus.s_valid && s_ready_c;
   assign last_entry = ({1'b0, idx_q} == (count_q - CW'(1)));

   io_pattern_mem #(
      .WIDTH      (WIDTH),
      .HOLD_WIDTH (HOLD_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_addr  (count_q[AW-1:0]),
      .wr_value (bus.s_data),
      .wr_hold  (bus.s_hold),
      .rd_addr  (rd_addr),
      .rd_value (rd_value),
      .rd_hold  (rd_hold)
   );

   // State, counters and output register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         io_q    <= IDLE_VALUE;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         io_q    <= io_d;
      end
   end

   // Next state, table read address and next datapath values
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      io_d    = io_q;
      rd_addr = '0;

      if (wr_en) begin
         count_d = count_q + CW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.clear) begin
               count_d = '0;
            end else if (bus.start && (count_q != '0)) begin
               state_d = ST_PLAY;
               idx_d   = '0;
               hold_d  = rd_hold;
               io_d    = rd_value;
            end
         end
         ST_PLAY: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               io_d    = IDLE_VALUE;
            end else if (hold_q != '0) begin
               hold_d = hold_q - HOLD_WIDTH'(1);
            end else if (!last_entry) begin
               // advance with no gap cycle
               rd_addr = idx_q + AW'(1);
               idx_d   = rd_addr;
               hold_d  = rd_hold;
               io_d    = rd_value;
            end else if (bus.loop_en) begin
               // seamless wrap to entry 0
               idx_d  = '0;
               hold_d = rd_hold;
               io_d   = rd_value;
            end else begin
               state_d = ST_DONE;
               io_d    = IDLE_VALUE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            io_d    = IDLE_VALUE;
         end
         default: begin
            state_d = ST_IDLE;
            io_d    = IDLE_VALUE;
         end
      endcase
   end

   assign bus.s_ready = s_ready_c;
   assign bus.count   = count_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = (state_q == ST_DONE) && !bus.abort;
   assign bus.aborted = (state_q != ST_IDLE) && bus.abort;
   assign bus.io_out  = io_q;
endmodule

// File: tb/tb_io_pattern_sequencer.sv
// Randomized self-checking bench for io_pattern_sequencer. The reference model keeps the
// loaded table as queues and expands it into the expected per-cycle io_out stream.
module tb_io_pattern_sequencer;
   localparam int unsigned W  = 4;
   localparam int unsigned D  = 16;
   localparam int unsigned HW = 16;
   localparam logic [W-1:0] IDLE_V = 4'hC;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   io_pattern_sequencer_if #(.WIDTH(W), .HOLD_WIDTH(HW), .DEPTH(D)) bus ();

   io_pattern_sequencer #(
      .WIDTH(W), .DEPTH(D), .HOLD_WIDTH(HW), .IDLE_VALUE(IDLE_V)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   // model of the table contents
   logic [W-1:0]  tv[$];
   logic [HW-1:0] th[$];

   task automatic set_idle();
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_hold  = '0;
      bus.clear   = 1'b0;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.loop_en = 1'b0;
   endtask

   task automatic do_write(input logic [W-1:0] v, input logic [HW-1:0] h);
      @(negedge clk); set_idle();
      bus.s_valid = 1'b1; bus.s_data = v; bus.s_hold = h;
      #1;
      checks++;
      if (bus.s_ready !== (tv.size() < D))
         $display("FAIL write_ready: got %b want %b", bus.s_ready, (tv.size() < D));
      if (tv.size() < D) begin tv.push_back(v); th.push_back(h); end
   endtask

   task automatic check_count(input string name);
      @(negedge clk); set_idle(); #1;
      checks++;
      if (bus.count !== 5'(tv.size()))
         begin errors++; $display("FAIL %s count: got %0d want %0d", name, bus.count, tv.size()); end
   endtask

   task automatic do_clear();
      @(negedge clk); set_idle(); bus.clear = 1'b1; #1;
      checks++;
      if (bus.s_ready !== 1'b0)
         begin errors++; $display("FAIL clear_ready: got %b want 0", bus.s_ready); end
      tv.delete(); th.delete();
   endtask

   // Start playback and check every cycle against the expanded table stream.
   // abort_k < 0 means no abort; abort_k == total aborts in the completion cycle.
   task automatic run_play(input string name, input int passes, input int abort_k, input bit noise);
      logic [W-1:0] exp_q[$];
      int           pass_of[$];
      int           total;
      logic [W-1:0] exp_io;
      for (int p = 0; p < passes; p++)
         for (int e = 0; e < tv.size(); e++)
            for (int r = 0; r <= int'(th[e]); r++) begin
               exp_q.push_back(tv[e]); pass_of.push_back(p);
            end
      total = exp_q.size();
      @(negedge clk); set_idle(); bus.start = 1'b1; bus.loop_en = (passes > 1); #1;
      checks++;
      if (bus.busy !== 1'b0)
         begin errors++; $display("FAIL %s start_busy: got %b want 0", name, bus.busy); end
      for (int k = 0; k <= total; k++) begin
         @(negedge clk); set_idle();
         bus.loop_en = (k < total) ? (pass_of[k] < passes - 1) : 1'b0;
         if (noise) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = W'($urandom);
            bus.clear   = 1'($urandom_range(0, 1));
            bus.start   = 1'($urandom_range(0, 1));
         end
         if (k == abort_k) bus.abort = 1'b1;
         #1;
         exp_io = (k < total) ? exp_q[k] : IDLE_V;
         checks += 5;
         if (bus.io_out !== exp_io)
            begin errors++; $display("FAIL %s io_out[%0d]: got %h want %h", name, k, bus.io_out, exp_io); end
         if (bus.busy !== 1'b1)
            begin errors++; $display("FAIL %s busy[%0d]: got %b want 1", name, k, bus.busy); end
         if (bus.done !== (k == total && k != abort_k))
            begin errors++; $display("FAIL %s done[%0d]: got %b want %b", name, k, bus.done, (k == total && k != abort_k)); end
         if (bus.aborted !== (k == abort_k))
            begin errors++; $display("FAIL %s aborted[%0d]: got %b want %b", name, k, bus.aborted, (k == abort_k)); end
         if (bus.s_ready !== 1'b0)
            begin errors++; $display("FAIL %s ready_busy[%0d]: got %b want 0", name, k, bus.s_ready); end
         if (k == abort_k) break;
      end
      @(negedge clk); set_idle(); #1;
      checks += 5;
      if (bus.io_out !== IDLE_V)
         begin errors++; $display("FAIL %s end_io: got %h want %h", name, bus.io_out, IDLE_V); end
      if (bus.busy !== 1'b0)
         begin errors++; $display("FAIL %s end_busy: got %b want 0", name, bus.busy); end
      if (bus.done !== 1'b0)
         begin errors++; $display("FAIL %s end_done: got %b want 0", name, bus.done); end
      if (bus.aborted !== 1'b0)
         begin errors++; $display("FAIL %s end_aborted: got %b want 0", name, bus.aborted); end
      if (bus.count !== 5'(tv.size()))
         begin errors++; $display("FAIL %s end_count: got %0d want %0d", name, bus.count, tv.size()); end
   endtask

   task automatic test_reset();
      set_idle();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks += 6;
      if (bus.io_out !== IDLE_V) begin errors++; $display("FAIL reset io_out: got %h want %h", bus.io_out, IDLE_V); end
      if (bus.count !== '0)      begin errors++; $display("FAIL reset count: got %0d want 0", bus.count); end
      if (bus.s_ready !== 1'b1)  begin errors++; $display("FAIL reset s_ready: got %b want 1", bus.s_ready); end
      if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
      if (bus.done !== 1'b0)     begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
      if (bus.aborted !== 1'b0)  begin errors++; $display("FAIL reset aborted: got %b want 0", bus.aborted); end
      @(negedge clk); resetn = 1'b1;
   endtask

   task automatic test_basic();
      do_write(4'hA, 16'd0); do_write(4'h5, 16'd2); do_write(4'h3, 16'd1);
      check_count("basic_load");
      run_play("basic", 1, -1, 1'b0);
   endtask

   task automatic test_loop();
      run_play("loop", 2, -1, 1'b0);
   endtask

   task automatic test_abort();
      run_play("abort_play", 1, 2, 1'b0);
      run_play("abort_done", 1, 6, 1'b0);
   endtask

   task automatic test_random();
      int n, passes, total, ak;
      for (int it = 0; it < 6; it++) begin
         do_clear();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) do_write(W'($urandom), HW'($urandom_range(0, 3)));
         check_count("rand_load");
         passes = $urandom_range(1, 3);
         total = 0;
         for (int e = 0; e < tv.size(); e++) total += int'(th[e]) + 1;
         total *= passes;
         ak = ($urandom_range(0, 1) == 1) ? $urandom_range(0, total) : -1;
         run_play("random", passes, ak, 1'b1);
         run_play("replay", 1, -1, 1'b0);
      end
   endtask

   task automatic test_full();
      do_clear();
      for (int i = 0; i < D; i++) do_write(W'($urandom), HW'($urandom_range(0, 1)));
      do_write(4'h1, 16'd0);
      check_count("full");
      run_play("full_play", 1, -1, 1'b0);
      @(negedge clk); set_idle(); bus.clear = 1'b1; bus.start = 1'b1; #1;
      checks++;
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL clr_start ready: got %b want 0", bus.s_ready); end
      tv.delete(); th.delete();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); set_idle(); #1;
         checks += 3;
         if (bus.count !== '0)   begin errors++; $display("FAIL clr_start count: got %0d want 0", bus.count); end
         if (bus.busy !== 1'b0)  begin errors++; $display("FAIL clr_start busy: got %b want 0", bus.busy); end
         if (bus.done !== 1'b0)  begin errors++; $display("FAIL clr_start done: got %b want 0", bus.done); end
      end
   endtask

   task automatic test_empty_and_async_reset();
      @(negedge clk); set_idle(); bus.start = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); set_idle(); #1;
         checks += 3;
         if (bus.busy !== 1'b0)     begin errors++; $display("FAIL empty busy: got %b want 0", bus.busy); end
         if (bus.io_out !== IDLE_V) begin errors++; $display("FAIL empty io_out: got %h want %h", bus.io_out, IDLE_V); end
         if (bus.aborted !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL empty pulses: got %b%b want 00", bus.done, bus.aborted); end
      end
      do_write(4'h6, 16'd3); do_write(4'h9, 16'd3);
      @(negedge clk); set_idle(); bus.start = 1'b1;
      @(negedge clk); set_idle();
      @(negedge clk); #1;
      checks++;
      if (bus.io_out !== 4'h6) begin errors++; $display("FAIL areset pre io_out: got %h want 6", bus.io_out); end
      #1 resetn = 1'b0;
      #1;
      tv.delete(); th.delete();
      checks += 4;
      if (bus.io_out !== IDLE_V) begin errors++; $display("FAIL areset io_out: got %h want %h", bus.io_out, IDLE_V); end
      if (bus.busy !== 1'b0)     begin errors++; $display("FAIL areset busy: got %b want 0", bus.busy); end
      if (bus.count !== '0)      begin errors++; $display("FAIL areset count: got %0d want 0", bus.count); end
      if (bus.s_ready !== 1'b1)  begin errors++; $display("FAIL areset s_ready: got %b want 1", bus.s_ready); end
      @(negedge clk); resetn = 1'b1;
      check_count("post_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loop();
      test_abort();
      test_random();
      test_full();
      test_empty_and_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
